// File: rtl/data_rate_pkg.sv
// Shared types, widths and the rate-mismatch compare for the data-rate window controller.
package data_rate_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int STAT_W_DEF = 16;
    localparam int CMP_MAX_W  = 64;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // True when |diff| > thr; diff is sign-extended and thr zero-extended to CMP_MAX_W bits.
    function automatic logic exceeds_threshold(
        input logic [CMP_MAX_W:0]   diff,
        input logic [CMP_MAX_W-1:0] thr
    );
        logic [CMP_MAX_W:0] mag;
        mag = diff[CMP_MAX_W] ? ((~diff) + (CMP_MAX_W+1)'(1)) : diff;
        return mag > {1'b0, thr};
    endfunction

endpackage

// File: rtl/data_rate_window_ctrl_timer.sv
// Loadable down-counter that stops at zero and flags the terminal count.
module rate_window_timer (
    input  logic        plf_clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        dec,
    output logic        tc
);

    logic [31:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge plf_clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 32'd1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/data_rate_window_ctrl.sv
// Measurement-window scheduler: snapshots two free-running dword counters per window
// and reports their deltas, signed difference, threshold mismatch and statistics.
module data_rate_window_ctrl
    import data_rate_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              plf_clk,
    input  logic              rst,
    input  logic              cfg_enable,
    input  logic              cfg_oneshot,
    input  logic              cfg_start,
    input  logic              cfg_clr_stats,
    input  logic [31:0]       cfg_window_cycles,
    input  logic [CNT_W-1:0]  cfg_threshold,
    input  logic [CNT_W-1:0]  dwords_fifo_wdata,
    input  logic [CNT_W-1:0]  dwords_mac_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  rate_fifo,
    output logic [CNT_W-1:0]  rate_mac,
    output logic [CNT_W:0]    rate_diff,
    output logic              rate_valid,
    output logic              mismatch,
    output logic [STAT_W-1:0] mismatch_cnt,
    output logic [31:0]       window_cnt
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] base_fifo, base_mac, shadow_thr;
    logic             cmp_armed;
    logic             capture, win_end, tmr_dec, tmr_tc;
    logic [CNT_W:0]   diff_nxt;
    logic             mm_nxt;

    rate_window_timer u_timer (
        .plf_clk  (plf_clk),
        .rst      (rst),
        .load     (capture),
        .load_val (cfg_window_cycles - 32'd1),
        .dec      (tmr_dec),
        .tc       (tmr_tc)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        win_end   = 1'b0;
        tmr_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start && cfg_enable && cfg_window_cycles != '0) begin
                    state_nxt = MEASURE;
                    capture   = 1'b1;
                end
            end
            MEASURE: begin
                if (!cfg_enable) begin
                    state_nxt = IDLE;
                end else if (!tmr_tc) begin
                    tmr_dec = 1'b1;
                end else begin
                    win_end = 1'b1;
                    // Continuous mode re-bases on the end edge itself, so no dword falls between windows.
                    if (!cfg_oneshot && cfg_window_cycles != '0) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == MEASURE);
    assign diff_nxt = {1'b0, rate_fifo} - {1'b0, rate_mac};
    assign mm_nxt   = exceeds_threshold(
                          {{(CMP_MAX_W - CNT_W){diff_nxt[CNT_W]}}, diff_nxt},
                          {{(CMP_MAX_W - CNT_W){1'b0}}, shadow_thr});

    always_ff @(posedge plf_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base_fifo  <= '0;
            base_mac   <= '0;
            shadow_thr <= '0;
            rate_fifo  <= '0;
            rate_mac   <= '0;
            cmp_armed  <= 1'b0;
            rate_diff  <= '0;
            mismatch   <= 1'b0;
            rate_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                base_fifo  <= dwords_fifo_wdata;
                base_mac   <= dwords_mac_rdata;
                shadow_thr <= cfg_threshold;
            end
            if (win_end) begin
                rate_fifo <= dwords_fifo_wdata - base_fifo;
                rate_mac  <= dwords_mac_rdata - base_mac;
            end
            // The compare stage runs regardless of cfg_enable: its rates are already final.
            cmp_armed  <= win_end;
            rate_valid <= cmp_armed;
            if (cmp_armed) begin
                rate_diff <= diff_nxt;
                mismatch  <= mm_nxt;
            end
        end
    end

    always_ff @(posedge plf_clk or posedge rst) begin
        if (rst) begin
            mismatch_cnt <= '0;
            window_cnt   <= '0;
        end else if (cfg_clr_stats) begin
            mismatch_cnt <= '0;
            window_cnt   <= '0;
        end else if (cmp_armed) begin
            window_cnt <= window_cnt + 32'd1;
            if (mm_nxt && mismatch_cnt != '1) begin
                mismatch_cnt <= mismatch_cnt + STAT_W'(1);
            end
        end
    end

endmodule

// File: doc/data_rate_window_ctrl.md
Name:
data_rate_window_ctrl

Overview:
- Measurement-window scheduler for the dword traffic counters in the plf_clk domain: the host-side AXI FIFO write count and the MAC SRAM read count.
- Opens a programmable window of plf_clk cycles and snapshots both free-running 32-bit counters at the window edges.
- Produces per-window dword deltas (rates), their signed difference and a threshold-based mismatch flag and statistics.
- Sits between the counter block and the register file / interrupt logic. Runs one-shot or back-to-back continuous windows.

Parameters:
- CNT_W, 32, width of the input dword counters and of the rate outputs.
- STAT_W, 16, width of the saturating mismatch counter.

Ports:
- plf_clk  in  1  block clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_enable  in  1  level; low aborts any window and holds the FSM in IDLE.
- cfg_oneshot  in  1  1 = single window per start; 0 = continuous back-to-back windows.
- cfg_start  in  1  one-cycle pulse; opens the first window.
- cfg_clr_stats  in  1  one-cycle pulse; clears mismatch_cnt and window_cnt.
- cfg_window_cycles  in  32  window length in plf_clk cycles; 0 is illegal.
- cfg_threshold  in  CNT_W  allowed |fifo − mac| per window.
- dwords_fifo_wdata  in  CNT_W  free-running FIFO write dword counter, plf_clk domain.
- dwords_mac_rdata  in  CNT_W  free-running MAC read dword counter, already synchronised to plf_clk upstream.
- busy  out  1  high while a window is open.
- rate_fifo  out  CNT_W  FIFO dwords in the last completed window.
- rate_mac  out  CNT_W  MAC dwords in the last completed window.
- rate_diff  out  CNT_W+1  signed two's complement rate_fifo − rate_mac.
- rate_valid  out  1  one-cycle pulse when rate_diff, mismatch and counters are updated.
- mismatch  out  1  level; result of the last compare, |rate_diff| > cfg_threshold.
- mismatch_cnt  out  STAT_W  count of mismatching windows; saturates at all-ones.
- window_cnt  out  32  count of completed windows; wraps modulo 2^32.

Behaviour:
- Reset: every output is 0; FSM is IDLE; internal base, shadow and timer registers are 0.
- FSM states:
  - IDLE → MEASURE on cfg_start & cfg_enable & (cfg_window_cycles != 0).
  - At that edge: base_fifo/base_mac ← current counter inputs; shadow_win ← cfg_window_cycles; shadow_thr ← cfg_threshold; timer ← cfg_window_cycles − 1.
  - cfg_start with cfg_window_cycles = 0, or with cfg_enable low, is ignored.
- MEASURE:
  - busy = 1.
  - Each edge with timer != 0: timer ← timer − 1.
  - Edge with timer == 0 is the end edge E:
    - rate_fifo ← dwords_fifo_wdata − base_fifo; rate_mac ← dwords_mac_rdata − base_mac; both modulo 2^CNT_W, so counter wrap through all-ones → 0 needs no special case.
    - Compare stage is armed.
    - If cfg_oneshot = 0: base ← current inputs at E (no gap cycle between windows); timer ← cfg_window_cycles − 1; shadows reload from cfg. Stay in MEASURE.
    - If cfg_oneshot = 1, or cfg_window_cycles = 0 at E: go to IDLE.
  - cfg_enable low in any MEASURE cycle, including E: go to IDLE at that edge. No rate update, no compare, no window_cnt increment. This is an abort.
  - cfg_start while in MEASURE is ignored.
- Window length: exactly shadow_win edges between the base-capture edge and E. A length of 1 gives E on the first edge after start.
- Compare stage, edge E+1:
  - rate_diff ← {0,rate_fifo} − {0,rate_mac}.
  - mismatch ← |diff| > shadow_thr, evaluated at CNT_W+1 bits with no overflow.
  - mismatch_cnt increments when mismatch is set; holds at all-ones.
  - window_cnt ← window_cnt + 1.
  - rate_valid = 1 for exactly the cycle after E+1.
- rate_fifo/rate_mac hold between windows; a new window does not clear them.
- cfg_clr_stats coincident with an increment: clear wins, giving 0. rate and mismatch outputs are unaffected.
- Abort at E+1 (cfg_enable low while the compare stage is armed): the compare still completes, because the rates are already valid.

Decomposition:
- Shared package data_rate_pkg: FSM state enum {IDLE, MEASURE}, CNT_W and STAT_W defaults, and the mismatch compare function (signed abs against threshold).
- One natural sub-module: rate_window_timer, a loadable down-counter with a terminal-count output.
- All other logic is flat in the top.

Test Plan:
- One-shot, window = 100, FIFO counter +1 each cycle, MAC +1 every second cycle from 0 → rate_fifo = 100, rate_mac = 50, rate_diff = +50; with threshold 10: mismatch = 1, mismatch_cnt = 1, window_cnt = 1, rate_valid pulses once, busy falls.
- Counter wrap: base_fifo = 0xFFFF_FFF0, window = 32, FIFO +1 per cycle → rate_fifo = 32.
- Continuous, window = 10, 5 windows, equal increments, threshold 0 → 5 rate_valid pulses spaced exactly 10 cycles apart, mismatch = 0, window_cnt = 5, no dropped counts across window boundaries.
- Abort: cfg_enable low at cycle 50 of a 100-cycle window → no rate_valid, outputs hold their previous values, FSM in IDLE, busy = 0.
- cfg_window_cycles = 0 with cfg_start → FSM stays IDLE. Window = 1 → rate_valid two cycles after start.
- mismatch_cnt preset to 0xFFFF via repeated mismatches, or STAT_W = 2 → saturates at all-ones. cfg_clr_stats coincident with a mismatch → mismatch_cnt = 0.
